// File: rtl/via_irq_pkg.sv
// Shared VIA header: interrupt source bit positions, IFR/IER
// register codes and access-kind type used across the VIA blocks.
package via_irq_pkg;

  localparam int unsigned NSRC = 7;

  typedef logic [NSRC-1:0] irq_vec_t;

  // Bit positions of each interrupt source in IFR/IER.
  typedef enum int unsigned {
    SRC_CA2 = 0,
    SRC_CA1 = 1,
    SRC_SR  = 2,
    SRC_CB2 = 3,
    SRC_CB1 = 4,
    SRC_T2  = 5,
    SRC_T1  = 6
  } src_e;

  // Register select codes within the IFR/IER pair.
  typedef enum logic {
    ADDR_IFR = 1'b0,
    ADDR_IER = 1'b1
  } reg_addr_e;

  typedef enum logic [1:0] {
    ACC_NONE,
    ACC_RD,
    ACC_IFR_WR,
    ACC_IER_WR
  } acc_e;

  // IER write: bit 7 chooses set (1) or clear (0) of the masked bits.
  function automatic irq_vec_t ier_apply(
    input irq_vec_t   cur,
    input logic [7:0] wd
  );
    irq_vec_t r;
    if (wd[7]) r = cur | wd[NSRC-1:0];
    else       r = cur & ~wd[NSRC-1:0];
    return r;
  endfunction

endpackage

// File: rtl/via_irq_ctrl.sv
// VIA interrupt flag/enable controller (IFR/IER, irq_n).
// Ports: clk, reset (sync, high), en, set_pulse[6:0], clr_req[6:0],
// cs, rnw, addr, data_in[7:0] -> data_out[7:0], irq_n.
// Macro VIA_IRQ_REG_EN: registered irq_n (one clk late, not en-gated).
module via_irq_ctrl
  import via_irq_pkg::*;
#(
  parameter logic [6:0] IER_RST = 7'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [6:0] set_pulse,
  input  logic [6:0] clr_req,
  input  logic       cs,
  input  logic       rnw,
  input  logic       addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       irq_n
);

  irq_vec_t ifr_q;
  irq_vec_t ier_q;
  irq_vec_t ifr_d;
  irq_vec_t ier_d;
  irq_vec_t wr_clr;
  acc_e     acc;
  logic     any;

  always_comb begin
    acc = ACC_NONE;
    unique case (1'b1)
      !cs:
        acc = ACC_NONE;
      cs && rnw:
        acc = ACC_RD;
      cs && !rnw && (addr == ADDR_IFR):
        acc = ACC_IFR_WR;
      cs && !rnw && (addr == ADDR_IER):
        acc = ACC_IER_WR;
    endcase
  end

  // Set is OR'd in after the clear so a coincident
  // set and clear leaves the flag set.
  always_comb begin
    ifr_d  = ifr_q;
    ier_d  = ier_q;
    wr_clr = '0;
    if (acc == ACC_IFR_WR)
      wr_clr = data_in[NSRC-1:0];
    if (en) begin
      ifr_d = (ifr_q & ~(clr_req | wr_clr))
            | set_pulse;
      if (acc == ACC_IER_WR)
        ier_d = ier_apply(ier_q, data_in);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ifr_q <= '0;
      ier_q <= IER_RST;
    end else begin
      ifr_q <= ifr_d;
      ier_q <= ier_d;
    end
  end

  assign any = |(ifr_q & ier_q);

  always_comb begin
    data_out = 8'h00;
    if (cs) begin
      if (addr == ADDR_IFR)
        data_out = {any, ifr_q};
      else
        data_out = {1'b1, ier_q};
    end
  end

`ifdef VIA_IRQ_REG_EN
  logic irq_q;

  // Runs on every clk, independent of the phase strobe.
  always_ff @(posedge clk) begin
    if (reset) irq_q <= 1'b1;
    else       irq_q <= ~any;
  end

  assign irq_n = irq_q;
`else
  assign irq_n = ~any;
`endif

endmodule
